// File: rtl/hex_record_parser.sv
// hex_record_parser: Intel-HEX character stream parser.
// Takes one ASCII character per accepted cycle, assembles records
// (start code, count, address, type, data, checksum), emits type-00 data
// bytes with absolute addresses over a valid/ready handshake, and reports
// record completion, errors and end-of-file.
//
// Ports:
//   CLK         system clock, rising edge
//   RESET_N     asynchronous reset, active-low
//   CHAR        ASCII character in
//   CHAR_VALID  CHAR is valid this cycle
//   CHAR_READY  parser accepts CHAR this cycle (combinational)
//   DATA        decoded data byte
//   ADDR        absolute address of DATA
//   DATA_VALID  DATA/ADDR valid, held until DATA_READY
//   DATA_READY  consumer accepts DATA
//   REC_DONE    one-cycle pulse at the end of every record
//   REC_ERR     qualifies REC_DONE: checksum or format error
//   EOF         sticky, set by a good type-01 record
module hex_record_parser #(
  parameter int unsigned ADDR_W   = 16,
  parameter bit          LOWER_OK = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [7:0]        CHAR,
  input  logic              CHAR_VALID,
  output logic              CHAR_READY,
  output logic [7:0]        DATA,
  output logic [ADDR_W-1:0] ADDR,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              REC_DONE,
  output logic              REC_ERR,
  output logic              EOF
);

  // Upper address register is kept at least one bit wide so ADDR_W=16 elaborates.
  localparam int unsigned UPPER_W = (ADDR_W > 16) ? ADDR_W - 16 : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_ADDR,
    S_TYPE,
    S_DATA,
    S_CSUM
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_have_hi, w_have_hi_nxt;
  logic [3:0]          r_hi, w_hi_nxt;
  logic [7:0]          r_count, w_count_nxt;
  logic                r_bsel, w_bsel_nxt;
  logic [15:0]         r_rec_addr, w_rec_addr_nxt;
  logic [7:0]          r_type, w_type_nxt;
  logic [7:0]          r_idx, w_idx_nxt;
  logic [7:0]          r_sum, w_sum_nxt;
  logic                r_fmt_err, w_fmt_err_nxt;
  logic [15:0]         r_d04, w_d04_nxt;
  logic [UPPER_W-1:0]  r_upper, w_upper_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_data_valid, w_data_valid_nxt;
  logic                r_rec_done, w_rec_done_nxt;
  logic                r_rec_err, w_rec_err_nxt;
  logic                r_eof, w_eof_nxt;

  logic                w_accept;
  logic                w_is_hex;
  logic                w_is_colon;
  logic [3:0]          w_nib;
  logic [7:0]          w_byte;
  logic [7:0]          w_sum_add;
  logic [15:0]         w_low_addr;

  // Input stalls only while an emitted byte is waiting for the consumer.
  assign CHAR_READY = !(r_data_valid && !DATA_READY);
  assign w_accept   = CHAR_VALID && CHAR_READY;
  assign w_is_colon = (CHAR == 8'h3A);
  assign w_byte     = {r_hi, w_nib};
  assign w_sum_add  = 8'(r_sum + w_byte);
  assign w_low_addr = 16'(r_rec_addr + {8'h00, r_idx});

  assign DATA       = r_data;
  assign ADDR       = r_addr;
  assign DATA_VALID = r_data_valid;
  assign REC_DONE   = r_rec_done;
  assign REC_ERR    = r_rec_err;
  assign EOF        = r_eof;

  // ASCII hex digit decode.
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (CHAR >= 8'h30 && CHAR <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(CHAR - 8'h30);
    end else if (CHAR >= 8'h41 && CHAR <= 8'h46) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(CHAR - 8'h37);
    end else if (LOWER_OK && CHAR >= 8'h61 && CHAR <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(CHAR - 8'h57);
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath and output decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_have_hi_nxt    = r_have_hi;
    w_hi_nxt         = r_hi;
    w_count_nxt      = r_count;
    w_bsel_nxt       = r_bsel;
    w_rec_addr_nxt   = r_rec_addr;
    w_type_nxt       = r_type;
    w_idx_nxt        = r_idx;
    w_sum_nxt        = r_sum;
    w_fmt_err_nxt    = r_fmt_err;
    w_d04_nxt        = r_d04;
    w_upper_nxt      = r_upper;
    w_data_nxt       = r_data;
    w_addr_nxt       = r_addr;
    w_data_valid_nxt = r_data_valid && !DATA_READY;
    w_rec_done_nxt   = 1'b0;
    w_rec_err_nxt    = 1'b0;
    w_eof_nxt        = r_eof;

    if (w_accept) begin
      if (w_is_colon) begin
        // A start code always begins a new record; mid-record it aborts the old one.
        if (r_state != S_IDLE) begin
          w_rec_done_nxt = 1'b1;
          w_rec_err_nxt  = 1'b1;
        end
        w_state_nxt   = S_COUNT;
        w_sum_nxt     = 8'h00;
        w_eof_nxt     = 1'b0;
        w_have_hi_nxt = 1'b0;
        w_fmt_err_nxt = 1'b0;
      end else if (r_state != S_IDLE) begin
        if (!w_is_hex) begin
          w_rec_done_nxt = 1'b1;
          w_rec_err_nxt  = 1'b1;
          w_state_nxt    = S_IDLE;
          w_have_hi_nxt  = 1'b0;
        end else if (!r_have_hi) begin
          w_hi_nxt      = w_nib;
          w_have_hi_nxt = 1'b1;
        end else begin
          w_have_hi_nxt = 1'b0;
          w_sum_nxt     = w_sum_add;
          case (r_state)
            S_COUNT: begin
              w_count_nxt = w_byte;
              w_bsel_nxt  = 1'b0;
              w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
              if (!r_bsel) begin
                w_rec_addr_nxt = {w_byte, r_rec_addr[7:0]};
                w_bsel_nxt     = 1'b1;
              end else begin
                w_rec_addr_nxt = {r_rec_addr[15:8], w_byte};
                w_state_nxt    = S_TYPE;
              end
            end
            S_TYPE: begin
              w_type_nxt = w_byte;
              w_idx_nxt  = 8'h00;
              if ((w_byte == 8'h01 && r_count != 8'h00) ||
                  (w_byte == 8'h04 && r_count != 8'h02)) begin
                w_fmt_err_nxt = 1'b1;
              end
              w_state_nxt = (r_count == 8'h00) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
              if (r_type == 8'h00) begin
                w_data_nxt       = w_byte;
                w_addr_nxt       = ADDR_W'({r_upper, w_low_addr});
                w_data_valid_nxt = 1'b1;
              end
              if (r_idx == 8'h00) begin
                w_d04_nxt = {w_byte, r_d04[7:0]};
              end else if (r_idx == 8'h01) begin
                w_d04_nxt = {r_d04[15:8], w_byte};
              end
              w_idx_nxt = 8'(r_idx + 8'd1);
              if (r_idx == 8'(r_count - 8'd1)) begin
                w_state_nxt = S_CSUM;
              end
            end
            S_CSUM: begin
              w_rec_done_nxt = 1'b1;
              w_rec_err_nxt  = (w_sum_add != 8'h00) || r_fmt_err;
              if (w_sum_add == 8'h00 && !r_fmt_err) begin
                if (r_type == 8'h01) begin
                  w_eof_nxt = 1'b1;
                end
                // Upper address changes only once the whole record checks out.
                if (r_type == 8'h04 && ADDR_W > 16) begin
                  w_upper_nxt = UPPER_W'(r_d04);
                end
              end
              w_state_nxt = S_IDLE;
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_have_hi    <= 1'b0;
      r_hi         <= 4'h0;
      r_count      <= 8'h00;
      r_bsel       <= 1'b0;
      r_rec_addr   <= 16'h0000;
      r_type       <= 8'h00;
      r_idx        <= 8'h00;
      r_sum        <= 8'h00;
      r_fmt_err    <= 1'b0;
      r_d04        <= 16'h0000;
      r_upper      <= '0;
      r_data       <= 8'h00;
      r_addr       <= '0;
      r_data_valid <= 1'b0;
      r_rec_done   <= 1'b0;
      r_rec_err    <= 1'b0;
      r_eof        <= 1'b0;
    end else begin
      r_have_hi    <= w_have_hi_nxt;
      r_hi         <= w_hi_nxt;
      r_count      <= w_count_nxt;
      r_bsel       <= w_bsel_nxt;
      r_rec_addr   <= w_rec_addr_nxt;
      r_type       <= w_type_nxt;
      r_idx        <= w_idx_nxt;
      r_sum        <= w_sum_nxt;
      r_fmt_err    <= w_fmt_err_nxt;
      r_d04        <= w_d04_nxt;
      r_upper      <= w_upper_nxt;
      r_data       <= w_data_nxt;
      r_addr       <= w_addr_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_rec_done   <= w_rec_done_nxt;
      r_rec_err    <= w_rec_err_nxt;
      r_eof        <= w_eof_nxt;
    end
  end

endmodule

// File: doc/hex_record_parser.md
Name: hex_record_parser

Overview:
- Sequential successor to the single-character ASCII hex decoder in HEX2BIN.
- Consumes an ASCII Intel-HEX character stream, one character per accepted cycle, and parses complete records: start code, byte count, address, record type, data and checksum.
- Emits data bytes with their absolute addresses through a valid/ready handshake.
- Reports record completion, checksum and format errors, and end-of-file. Sits between the UART/character source and the binary memory writer.

Parameters:
ADDR_W, 16, output address width; legal 16..32. When ADDR_W>16, type-04 records supply the upper bits.
LOWER_OK, 1, 1 = also accept 'a'..'f' as hex digits; 0 = upper case only.

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET_N  input  1  asynchronous reset, active-low
CHAR  input  8  ASCII character
CHAR_VALID  input  1  CHAR is valid this cycle
CHAR_READY  output  1  parser accepts CHAR this cycle
DATA  output  8  decoded data byte
ADDR  output  ADDR_W  absolute address of DATA
DATA_VALID  output  1  DATA/ADDR valid; held until accepted
DATA_READY  input  1  consumer accepts DATA
REC_DONE  output  1  one-cycle pulse at the end of each record, good or bad
REC_ERR  output  1  qualifies REC_DONE: checksum or format error
EOF  output  1  sticky; set by a good type-01 record

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE; DATA=0, ADDR=0, DATA_VALID=0, REC_DONE=0, REC_ERR=0, EOF=0; upper address register=0.
- Accept rule: a character is consumed when CHAR_VALID && CHAR_READY. CHAR_READY = !(DATA_VALID && !DATA_READY).
- Hex decode: '0'-'9' give 0-9. 'A'-'F' give 10-15. 'a'-'f' give 10-15 only when LOWER_OK=1.
- Nibble assembly: two consecutive hex characters form one byte, first character in the high nibble.
- State machine: IDLE -> COUNT(2 chars) -> ADDR(4) -> TYPE(2) -> DATA(2*count; skipped if count=0) -> CSUM(2) -> IDLE.
- IDLE: ':' moves to COUNT and clears the running sum and the EOF flag. Any other character, including CR/LF, is ignored.
- Running sum: 8-bit, modulo 256. Accumulates every byte from count through checksum. A record is good when the final sum is 0x00.
- Type 00 data bytes:
  - DATA_VALID rises the cycle after the second nibble of each byte is accepted.
  - ADDR = {upper, rec_addr + index}. The low 16 bits wrap modulo 2^16 and do not carry into the upper bits.
  - Bytes are emitted before the checksum is known; the consumer discards them on REC_ERR.
- Type 01: a good record sets EOF. Count must be 0, otherwise format error.
- Type 04:
  - Count must be 2, otherwise format error.
  - A good record loads upper = data[ADDR_W-17:0], taken from the 16-bit data value.
  - With ADDR_W=16, the record is checked but has no effect.
  - The upper-address update takes effect only after checksum pass.
- Other record types: parsed and checksummed, data not emitted.
- REC_DONE / REC_ERR: REC_DONE pulses the cycle after the last checksum character is accepted. REC_ERR = (sum != 0) or a format error latched during the record.
- Format error mid-record:
  - A non-hex, non-':' character outside IDLE causes REC_DONE=1 with REC_ERR=1 on the next cycle.
  - The state returns to IDLE.
- ':' mid-record: the current record is aborted, giving REC_DONE=1 with REC_ERR=1. The new record starts immediately in COUNT with the sum cleared.
- Simultaneous events: the DATA_VALID handshake and the final-checksum REC_DONE may coincide. Both are honoured.
- Reset mid-record: all partial state is discarded.

Test Plan:
- ":0300300002337A1E" -> DATA 02@0x0030, 33@0x0031, 7A@0x0032; REC_DONE=1, REC_ERR=0.
- Same record with checksum "1F" -> the three bytes are still emitted; REC_DONE=1, REC_ERR=1.
- ADDR_W=32 stream:
  - ":020000040001F9" sets upper to 0x0001.
  - ":0100000055AA" then gives DATA 0x55 @0x00010000.
- ":00000001FF" -> REC_DONE, REC_ERR=0, EOF=1. A subsequent ':' clears EOF.
- Hold DATA_READY=0 for 5 cycles during a data byte -> DATA_VALID and DATA stay stable, CHAR_READY=0, no character is lost.
- ":03003G" -> REC_ERR pulse on 'G', state IDLE.
- ":0300:0100000055AA" -> error pulse on the second ':', then good parse of the new record.
- LOWER_OK=0 with lowercase 'a' -> format error.
- Assert RESET_N low mid-data -> all outputs return to 0 asynchronously.
